// File: rtl/arb_mux_2_1_if.sv
// Two-channel request/out handshake bundle for arb_mux_2_1.
// slave = arbiter view, master = environment view.
interface arb_mux_2_1_if #(
  parameter int DW = 1
);
  logic          req0_valid;
  logic [DW-1:0] req0_data;
  logic          req0_ready;
  logic          req1_valid;
  logic [DW-1:0] req1_data;
  logic          req1_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_src;
  logic          out_ready;

  modport slave (
    input  req0_valid, req0_data,
    input  req1_valid, req1_data,
    input  out_ready,
    output req0_ready, req1_ready,
    output out_valid, out_data, out_src
  );

  modport master (
    output req0_valid, req0_data,
    output req1_valid, req1_data,
    output out_ready,
    input  req0_ready, req1_ready,
    input  out_valid, out_data, out_src
  );
endinterface

// File: rtl/arb_mux_2_1.sv
// Round-robin 2:1 arbiter with a single registered output slot.
// ARB_GRANT_CNT_EN adds saturating per-channel grant counters.
module arb_mux_2_1 #(
  parameter int DW = 1
) (
  input  logic           clk,
  input  logic           rst,
  arb_mux_2_1_if.slave   bus
`ifdef ARB_GRANT_CNT_EN
  ,
  output logic [7:0]     gnt_cnt0,
  output logic [7:0]     gnt_cnt1
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] data_q, data_d;
  logic          src_q, src_d;
  // Index of the channel granted last; 1 after reset so ch0 wins first tie.
  logic          ptr_q, ptr_d;

  logic can_accept;
  logic g0, g1;
  logic xfer0, xfer1;

  // Grant selection and ready generation; readys held low during reset.
  always_comb begin
    can_accept = (state_q == EMPTY) | bus.out_ready;
    g0 = bus.req0_valid & (~bus.req1_valid | ptr_q);
    g1 = bus.req1_valid & (~bus.req0_valid | ~ptr_q);
    bus.req0_ready = ~rst & can_accept & g0;
    bus.req1_ready = ~rst & can_accept & g1;
    xfer0 = bus.req0_valid & bus.req0_ready;
    xfer1 = bus.req1_valid & bus.req1_ready;
  end

  // Next-state for the output slot and round-robin pointer.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    src_d   = src_q;
    ptr_d   = ptr_q;
    unique case (1'b1)
      xfer0: begin
        state_d = FULL;
        data_d  = bus.req0_data;
        src_d   = 1'b0;
        ptr_d   = 1'b0;
      end
      xfer1: begin
        state_d = FULL;
        data_d  = bus.req1_data;
        src_d   = 1'b1;
        ptr_d   = 1'b1;
      end
      default: begin
        if (state_q == FULL && bus.out_ready)
          state_d = EMPTY;
      end
    endcase
  end

  // Output slot and pointer registers; reset discards any held word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      src_q   <= 1'b0;
      ptr_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.out_valid = (state_q == FULL);
  assign bus.out_data  = data_q;
  assign bus.out_src   = src_q;

`ifdef ARB_GRANT_CNT_EN
  logic [7:0] cnt0_q, cnt1_q;

  // Per-channel transfer counters, saturating at 255.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= 8'd0;
      cnt1_q <= 8'd0;
    end else begin
      if (xfer0 && cnt0_q != 8'hFF)
        cnt0_q <= cnt0_q + 8'd1;
      if (xfer1 && cnt1_q != 8'hFF)
        cnt1_q <= cnt1_q + 8'd1;
    end
  end

  assign gnt_cnt0 = cnt0_q;
  assign gnt_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_arb_mux_2_1.sv
// Directed bench for arb_mux_2_1.
// Counter checks run only when ARB_GRANT_CNT_EN is defined.
module tb_arb_mux_2_1;
  localparam int DW = 8;
  localparam logic [DW-1:0] D0 = 8'h5A;
  localparam logic [DW-1:0] D1 = 8'hC3;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  arb_mux_2_1_if #(.DW(DW)) bus ();

`ifdef ARB_GRANT_CNT_EN
  logic [7:0] gnt_cnt0;
  logic [7:0] gnt_cnt1;
`endif

  arb_mux_2_1 #(.DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ARB_GRANT_CNT_EN
    ,
    .gnt_cnt0 (gnt_cnt0),
    .gnt_cnt1 (gnt_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag,
                         input logic v,
                         input logic [DW-1:0] d,
                         input logic s);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'(v));
    chk({tag, "_data"}, 32'(bus.out_data), 32'(d));
    chk({tag, "_src"}, 32'(bus.out_src), 32'(s));
  endtask

  task automatic chk_rdy(input string tag,
                         input logic r0,
                         input logic r1);
    #1;
    chk({tag, "_rdy0"}, 32'(bus.req0_ready), 32'(r0));
    chk({tag, "_rdy1"}, 32'(bus.req1_ready), 32'(r1));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req0_data  = '0;
    bus.req1_valid = 1'b0;
    bus.req1_data  = '0;
    bus.out_ready  = 1'b0;

    // Reset state, readys forced low during reset even with requests.
    step();
    step();
    chk_out("rst", 1'b0, 8'h00, 1'b0);
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.out_ready  = 1'b1;
    chk_rdy("rst_req", 1'b0, 1'b0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    rst = 1'b0;
    step();
    chk_out("idle", 1'b0, 8'h00, 1'b0);
    chk_rdy("idle", 1'b0, 1'b0);

    // Single channel-0 word, then valids drop: one-cycle out_valid.
    bus.req0_valid = 1'b1;
    bus.req0_data  = 8'h01;
    chk_rdy("single", 1'b1, 1'b0);
    step();
    chk_out("single", 1'b1, 8'h01, 1'b0);
    bus.req0_valid = 1'b0;
    chk_rdy("drain", 1'b0, 1'b0);
    step();
    chk_out("drain", 1'b0, 8'h01, 1'b0);

    // Lone channel 1 is granted irrespective of the pointer.
    bus.req1_valid = 1'b1;
    bus.req1_data  = 8'h77;
    chk_rdy("lone1", 1'b0, 1'b1);
    step();
    chk_out("lone1", 1'b1, 8'h77, 1'b1);
    bus.req1_valid = 1'b0;
    step();

    // Alternation under sustained ties after a fresh reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_data  = D0;
    bus.req1_valid = 1'b1;
    bus.req1_data  = D1;
    bus.out_ready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk_rdy($sformatf("rr%0d", i), (i % 2) == 0, (i % 2) == 1);
      step();
      chk_out($sformatf("rr%0d", i), 1'b1,
              (i % 2) == 0 ? D0 : D1, (i % 2) == 1);
    end

    // Stall: output held, no readys; resume grants channel 0.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_rdy($sformatf("stall%0d", i), 1'b0, 1'b0);
      step();
      chk_out($sformatf("stall%0d", i), 1'b1, D1, 1'b1);
    end
    bus.out_ready = 1'b1;
    chk_rdy("resume", 1'b1, 1'b0);
    step();
    chk_out("resume", 1'b1, D0, 1'b0);

    // Reset while full: word discarded, pointer back to ch0-wins.
    rst = 1'b1;
    chk_rdy("rstfull", 1'b0, 1'b0);
    step();
    rst = 1'b0;
    chk_out("rstfull", 1'b0, 8'h00, 1'b0);
    chk_rdy("post_rst", 1'b1, 1'b0);
    step();
    chk_out("post_rst", 1'b1, D0, 1'b0);

    // EMPTY accepts even with out_ready low, then holds.
    bus.req1_valid = 1'b0;
    bus.out_ready  = 1'b1;
    bus.req0_valid = 1'b0;
    step();
    chk_out("empty2", 1'b0, D0, 1'b0);
    bus.out_ready  = 1'b0;
    bus.req1_valid = 1'b1;
    bus.req1_data  = 8'h3C;
    chk_rdy("emptyacc", 1'b0, 1'b1);
    step();
    chk_out("emptyacc", 1'b1, 8'h3C, 1'b1);
    bus.req1_valid = 1'b0;
    step();
    chk_out("hold", 1'b1, 8'h3C, 1'b1);
    bus.out_ready = 1'b1;
    step();
    chk_out("hold_drain", 1'b0, 8'h3C, 1'b1);

`ifdef ARB_GRANT_CNT_EN
    // Saturating counters and reset clear.
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b0;
    bus.out_ready  = 1'b1;
    for (int i = 0; i < 300; i++) step();
    chk("cnt0_sat", 32'(gnt_cnt0), 32'd255);
    chk("cnt1_zero", 32'(gnt_cnt1), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.req0_valid = 1'b0;
    chk("cnt0_clr", 32'(gnt_cnt0), 32'd0);
    chk("cnt1_clr", 32'(gnt_cnt1), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
